// File: rtl/scr_stack_ctrl_if.sv
// Stack controller bus: operation request, scratch RAM port and status.
// The slave modport is the controller; master is the sequencer driving OP.
interface scr_stack_ctrl_if;
    logic [2:0] OP;
    logic [7:0] REG_DATA;
    logic [9:0] PC_DATA;
    logic [7:0] ADDR_IN;
    logic [7:0] SCR_ADDR;
    logic [9:0] SCR_DATA_IN;
    logic       SCR_WE;
    logic [7:0] SP;
    logic [8:0] DEPTH;
    logic       READY;
    logic       OVF;
    logic       UNF;

    modport slave (
        input  OP, REG_DATA, PC_DATA, ADDR_IN,
        output SCR_ADDR, SCR_DATA_IN, SCR_WE, SP, DEPTH, READY, OVF, UNF
    );

    modport master (
        output OP, REG_DATA, PC_DATA, ADDR_IN,
        input  SCR_ADDR, SCR_DATA_IN, SCR_WE, SP, DEPTH, READY, OVF, UNF
    );
endinterface

// File: rtl/scr_stack_ctrl.sv
// Scratch-RAM stack controller: clears the 256-entry RAM after reset, then
// serves push/pop/call/ret, direct store/load and stack-pointer writes.
module scr_stack_ctrl (
    input  logic            CLK,
    input  logic            RST,
    scr_stack_ctrl_if.slave bus
);

    typedef enum logic {CLEAR, RUN} state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_ST   = 3'b101,
        OP_LD   = 3'b110,
        OP_WSP  = 3'b111
    } op_t;

    state_t     state, state_nxt;
    op_t        op;
    logic [7:0] clr_cnt;
    logic [7:0] sp;
    logic [8:0] depth;
    logic       ovf, unf;
    logic       full, empty;

    assign op    = op_t'(bus.OP);
    assign full  = depth[8];
    assign empty = (depth == '0);

    assign bus.SP    = sp;
    assign bus.DEPTH = depth;
    assign bus.OVF   = ovf;
    assign bus.UNF   = unf;

    always_ff @(posedge CLK) begin
        if (RST) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == 8'hFF)
            state_nxt = RUN;
    end

    // clr_cnt wraps back to 0 on the final sweep edge, so RUN needs no extra clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_cnt <= '0;
            sp      <= '0;
            depth   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 8'd1;
        end else begin
            case (op)
                OP_PUSH, OP_CALL: begin
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        sp    <= sp - 8'd1;
                        depth <= depth + 9'd1;
                    end
                end
                OP_POP, OP_RET: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        sp    <= sp + 8'd1;
                        depth <= depth - 9'd1;
                    end
                end
                OP_WSP: begin
                    sp    <= bus.REG_DATA;
                    depth <= (bus.REG_DATA == '0) ? '0 : (9'd256 - {1'b0, bus.REG_DATA});
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Reset forces the sweep-start outputs even while the state register still says RUN.
    always_comb begin
        bus.SCR_ADDR    = '0;
        bus.SCR_DATA_IN = '0;
        bus.SCR_WE      = 1'b0;
        bus.READY       = 1'b0;
        if (RST || state == CLEAR) begin
            bus.SCR_ADDR = RST ? '0 : clr_cnt;
            bus.SCR_WE   = 1'b1;
        end else begin
            bus.READY    = 1'b1;
            bus.SCR_ADDR = sp;
            case (op)
                OP_PUSH, OP_CALL: begin
                    if (!full) begin
                        bus.SCR_ADDR    = sp - 8'd1;
                        bus.SCR_WE      = 1'b1;
                        bus.SCR_DATA_IN = (op == OP_CALL) ? bus.PC_DATA : {2'b00, bus.REG_DATA};
                    end
                end
                OP_ST: begin
                    bus.SCR_ADDR    = bus.ADDR_IN;
                    bus.SCR_WE      = 1'b1;
                    bus.SCR_DATA_IN = {2'b00, bus.REG_DATA};
                end
                OP_LD: bus.SCR_ADDR = bus.ADDR_IN;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/scr_stack_ctrl.md
SCR_STACK_CTRL -- requirements
Module: scr_stack_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 OP  in  3  operation: 000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 ST, 110 LD, 111 WSP.
REQ-005 REG_DATA  in  8  register-file value for PUSH, ST and WSP.
REQ-006 PC_DATA  in  10  return address for CALL.
REQ-007 ADDR_IN  in  8  direct address for ST and LD.
REQ-008 SCR_ADDR  out  8  scratch RAM address; combinational.
REQ-009 SCR_DATA_IN  out  10  scratch RAM write data; combinational.
REQ-010 SCR_WE  out  1  scratch RAM write enable; combinational.
REQ-011 SP  out  8  registered stack pointer.
REQ-012 DEPTH  out  9  registered occupied-entry count, 0..256.
REQ-013 READY  out  1  high when OP is accepted.
REQ-014 OVF, UNF  out  1 each  sticky overflow and underflow flags.

Function
REQ-015 The FSM SHALL have two states: CLEAR and RUN.
REQ-016 CLEAR: the block SHALL run an 8-bit sweep counter CLR_CNT 0..255, driving SCR_ADDR=CLR_CNT, SCR_DATA_IN=0 and SCR_WE=1, and SHALL ignore OP.
REQ-017 CLEAR SHALL move to RUN on the edge where CLR_CNT=255, so the sweep takes exactly 256 cycles.
REQ-018 READY SHALL be 0 in CLEAR and 1 in RUN.
REQ-019 In RUN with OP=NOP, the block SHALL drive SCR_WE=0 and SCR_ADDR=SP.
REQ-020 PUSH: the block SHALL drive SCR_ADDR=SP-1 mod 256, SCR_DATA_IN={2'b00,REG_DATA} and SCR_WE=1; on the edge it SHALL update SP<=SP-1 and DEPTH<=DEPTH+1.
REQ-021 CALL SHALL behave as PUSH, except that SCR_DATA_IN=PC_DATA.
REQ-022 POP and RET: the block SHALL drive SCR_ADDR=SP and SCR_WE=0, with data read combinationally by the consumer in the same cycle; on the edge it SHALL update SP<=SP+1 and DEPTH<=DEPTH-1.
REQ-023 ST SHALL drive SCR_ADDR=ADDR_IN, SCR_DATA_IN={2'b00,REG_DATA} and SCR_WE=1, leaving SP and DEPTH unchanged.
REQ-024 LD SHALL drive SCR_ADDR=ADDR_IN and SCR_WE=0, leaving SP and DEPTH unchanged.
REQ-025 WSP SHALL set SP<=REG_DATA, DEPTH<=(REG_DATA==0 ? 0 : 256-REG_DATA), OVF<=0 and UNF<=0, with SCR_WE=0.
REQ-026 SP arithmetic SHALL be 8-bit modulo 256: 0-1=255 and 255+1=0.
REQ-027 PUSH or CALL with DEPTH=256 SHALL force SCR_WE=0, hold SP and DEPTH, and set OVF.
REQ-028 POP or RET with DEPTH=0 SHALL hold SP and DEPTH, set UNF, and still drive SCR_ADDR=SP.
REQ-029 OVF and UNF SHALL remain set until RST or WSP.
REQ-030 SCR_DATA_IN SHALL be 0 whenever SCR_WE=0.

Reset
REQ-031 RST high at an edge SHALL set state=CLEAR, CLR_CNT=0, SP=0, DEPTH=0, OVF=0, UNF=0; it SHALL take priority over all OP values.
REQ-032 During RST and in the first CLEAR cycle, outputs SHALL be SCR_ADDR=0, SCR_WE=1, SCR_DATA_IN=0, READY=0.
REQ-033 RST asserted mid-sweep SHALL restart the sweep at address 0.
REQ-034 RST asserted in RUN SHALL discard SP and DEPTH and restart the sweep.

Verification
REQ-035 Reset then 256 idle cycles -> SCR_WE=1 with addresses 0..255 in order, READY rises in cycle 257, and the RAM model reads all zeros.
REQ-036 PUSH REG_DATA=0x5A from SP=0 -> write of 0x05A at address 0xFF, then SP=0xFF, DEPTH=1; POP -> SCR_ADDR=0xFF, then SP=0x00, DEPTH=0.
REQ-037 CALL PC_DATA=0x3C7 then RET -> 0x3C7 written at 0xFF and read back at 0xFF; SP ends at 0.
REQ-038 256 PUSHes then a 257th -> the 257th has SCR_WE=0, SP=0, DEPTH=256, OVF=1; WSP REG_DATA=0x80 -> SP=0x80, DEPTH=128, OVF=0.
REQ-039 POP at DEPTH=0 -> UNF=1, SP stays 0; ST ADDR_IN=0x10 REG_DATA=0xAB then LD 0x10 -> 0x0AB read with SP unchanged.
REQ-040 RST pulsed at sweep cycle 100 -> the sweep restarts at address 0 and READY is delayed a full 256 cycles.
